// File: rtl/hamming_encode_stream_if.sv
// Streaming handshake bundle for the SECDED encoder: data-in side, code-out side.
// The slave modport is the encoder's view; master is the producer/consumer view.
interface hamming_encode_stream_if;
    logic [7:1]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [12:1] out_code;
    logic        out_valid;
    logic        out_ready;
    logic        out_injected;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_code,
        output out_valid,
        input  out_ready,
        output out_injected
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_code,
        input  out_valid,
        output out_ready,
        input  out_injected
    );
endinterface

// File: rtl/hamming_encode_stream.sv
// Hamming(12,7) SECDED stream encoder with a one-entry output register,
// periodic error injection for exercising downstream decoders, and transfer counters.
module hamming_encode_stream #(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    hamming_encode_stream_if.slave bus,
    input  logic                  inj_en,
    input  logic [3:0]            inj_pos_a,
    input  logic [3:0]            inj_pos_b,
    input  logic [7:0]            inj_every,
    output logic [CNT_W-1:0]      word_cnt,
    output logic [CNT_W-1:0]      inj_cnt
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [12:1]      out_code_q, out_code_d;
    logic             out_valid_q, out_valid_d;
    logic             out_injected_q, out_injected_d;
    logic [7:0]       ic_q, ic_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] inj_cnt_q, inj_cnt_d;

    logic [12:1] clean_code;
    logic [12:1] flip_mask;
    logic [7:0]  every_m1;
    logic        inj_hit;
    logic        corrupt;
    logic        in_ready_w;
    logic        accept;
    logic        xfer;

    always_comb begin
        clean_code     = '0;
        clean_code[3]  = bus.in_data[1];
        clean_code[5]  = bus.in_data[2];
        clean_code[6]  = bus.in_data[3];
        clean_code[7]  = bus.in_data[4];
        clean_code[9]  = bus.in_data[5];
        clean_code[10] = bus.in_data[6];
        clean_code[11] = bus.in_data[7];
        clean_code[1]  = bus.in_data[1] ^ bus.in_data[2] ^ bus.in_data[4]
                       ^ bus.in_data[5] ^ bus.in_data[7];
        clean_code[2]  = bus.in_data[1] ^ bus.in_data[3] ^ bus.in_data[4]
                       ^ bus.in_data[6] ^ bus.in_data[7];
        clean_code[4]  = bus.in_data[2] ^ bus.in_data[3] ^ bus.in_data[4];
        clean_code[8]  = bus.in_data[5] ^ bus.in_data[6] ^ bus.in_data[7];
        // Overall parity covers the clean word so injected flips stay detectable.
        clean_code[12] = ^clean_code[11:1];
    end

    // OR of two one-hot matches: equal positions flip once, out-of-range positions match nothing.
    genvar gi;
    generate
        for (gi = 1; gi <= 12; gi++) begin : g_flip
            assign flip_mask[gi] = (inj_pos_a == 4'(gi)) || (inj_pos_b == 4'(gi));
        end
    endgenerate

    assign every_m1   = (inj_every == 8'd0) ? 8'd0 : inj_every - 8'd1;
    assign inj_hit    = inj_en && (ic_q == every_m1);
    assign corrupt    = inj_hit && (|flip_mask);
    assign in_ready_w = !rst && (!out_valid_q || bus.out_ready);
    assign accept     = bus.in_valid && in_ready_w;
    assign xfer       = out_valid_q && bus.out_ready;

    always_comb begin
        out_code_d     = out_code_q;
        out_valid_d    = out_valid_q;
        out_injected_d = out_injected_q;
        ic_d           = ic_q;
        word_cnt_d     = word_cnt_q;
        inj_cnt_d      = inj_cnt_q;

        if (accept) begin
            out_valid_d    = 1'b1;
            out_code_d     = clean_code ^ (inj_hit ? flip_mask : 12'h000);
            out_injected_d = corrupt;
        end else if (xfer) begin
            out_valid_d    = 1'b0;
        end

        if (!inj_en) begin
            ic_d = 8'd0;
        end else if (accept) begin
            ic_d = inj_hit ? 8'd0 : ic_q + 8'd1;
        end

        if (xfer && !(&word_cnt_q)) begin
            word_cnt_d = word_cnt_q + CNT_ONE;
        end
        if (xfer && out_injected_q && !(&inj_cnt_q)) begin
            inj_cnt_d = inj_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_code_q     <= '0;
            out_valid_q    <= 1'b0;
            out_injected_q <= 1'b0;
            ic_q           <= '0;
            word_cnt_q     <= '0;
            inj_cnt_q      <= '0;
        end else begin
            out_code_q     <= out_code_d;
            out_valid_q    <= out_valid_d;
            out_injected_q <= out_injected_d;
            ic_q           <= ic_d;
            word_cnt_q     <= word_cnt_d;
            inj_cnt_q      <= inj_cnt_d;
        end
    end

    assign bus.in_ready     = in_ready_w;
    assign bus.out_code     = out_code_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_injected = out_injected_q;
    assign word_cnt         = word_cnt_q;
    assign inj_cnt          = inj_cnt_q;
endmodule

// File: tb/tb_hamming_encode_stream.sv
// Bench for hamming_encode_stream: fixed vectors, exhaustive round trip, periodic
// injection, random backpressure and stall/reset, all scored against a queue model.
module tb_hamming_encode_stream;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             inj_en;
    logic [3:0]       inj_pos_a;
    logic [3:0]       inj_pos_b;
    logic [7:0]       inj_every;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] inj_cnt;

    hamming_encode_stream_if bus();

    hamming_encode_stream #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .inj_en    (inj_en),
        .inj_pos_a (inj_pos_a),
        .inj_pos_b (inj_pos_b),
        .inj_every (inj_every),
        .word_cnt  (word_cnt),
        .inj_cnt   (inj_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [12:1] code;
        logic        inj;
        logic [7:1]  data;
        int          nflip;
    } exp_t;

    typedef struct {
        logic [7:1]  d;
        logic        en;
        logic [3:0]  pa;
        logic [3:0]  pb;
        logic [12:1] code;
        logic        inj;
    } vec_t;

    exp_t exp_q[$];
    vec_t tab[8];
    int   checks = 0;
    int   failures = 0;
    logic m_valid = 1'b0;
    int   m_ic = 0;
    int   m_wcnt = 0;
    int   m_icnt = 0;

    // Parity bit 2^k covers every position whose index has bit k set.
    function automatic logic [12:1] enc(input logic [7:1] d);
        logic [12:1] c;
        logic        x;
        int          j;
        c = '0;
        j = 1;
        for (int p = 1; p <= 11; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            x = 1'b0;
            for (int p = 1; p <= 11; p++)
                if ((((p >> k) & 1) == 1) && (p != (1 << k))) x = x ^ c[p];
            c[1 << k] = x;
        end
        c[12] = ^c[11:1];
        return c;
    endfunction

    // Returns {single_error, double_error, corrected data}.
    function automatic logic [8:0] dec(input logic [12:1] cin);
        logic [12:1] c;
        logic [7:1]  d;
        int          s;
        logic        ov;
        int          j;
        c = cin;
        s = 0;
        for (int p = 1; p <= 11; p++) if (c[p]) s = s ^ p;
        ov = ^c;
        if (ov && s >= 1 && s <= 11) c[s] = ~c[s];
        j = 1;
        d = '0;
        for (int p = 1; p <= 11; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[j] = c[p];
                j++;
            end
        end
        return {ov, (!ov && s != 0), d};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Called mid low phase with inputs settled; checks outputs, updates model, then clocks.
    task automatic step(input bit use_tab, input logic [12:1] tcode, input logic tinj);
        exp_t        e;
        logic        exp_ready, acc, xf, hit;
        logic [12:1] mask;
        logic [8:0]  dr;
        int          em1;
        #1;
        exp_ready = !rst && (!m_valid || bus.out_ready);
        chk("in_ready", int'(bus.in_ready), int'(exp_ready));
        chk("out_valid", int'(bus.out_valid), int'(m_valid));
        chk("word_cnt", int'(word_cnt), m_wcnt);
        chk("inj_cnt", int'(inj_cnt), m_icnt);
        if (m_valid && exp_q.size() > 0) begin
            chk("out_code", int'(bus.out_code), int'(exp_q[0].code));
            chk("out_injected", int'(bus.out_injected), int'(exp_q[0].inj));
        end
        acc = !rst && bus.in_valid && exp_ready;
        xf  = !rst && m_valid && bus.out_ready;
        if (xf && exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            dr = dec(bus.out_code);
            if (e.nflip == 0) begin
                chk("dec_clean_flags", int'(dr[8:7]), 0);
                chk("dec_clean_data", int'(dr[6:0]), int'(e.data));
            end else if (e.nflip == 1) begin
                chk("dec_single_flags", int'(dr[8:7]), 2);
                chk("dec_single_data", int'(dr[6:0]), int'(e.data));
            end else begin
                chk("dec_double_flags", int'(dr[8:7]), 1);
            end
            if (m_wcnt < CNT_MAX) m_wcnt++;
            if (e.inj && m_icnt < CNT_MAX) m_icnt++;
        end
        em1 = (inj_every == 8'd0) ? 0 : int'(inj_every) - 1;
        hit = inj_en && (m_ic == em1);
        if (acc) begin
            for (int p = 1; p <= 12; p++)
                mask[p] = (int'(inj_pos_a) == p) || (int'(inj_pos_b) == p);
            e.data  = bus.in_data;
            e.nflip = hit ? $countones(mask) : 0;
            e.code  = use_tab ? tcode : (enc(bus.in_data) ^ (hit ? mask : 12'h000));
            e.inj   = use_tab ? tinj : (e.nflip > 0);
            exp_q.push_back(e);
        end
        if (rst || !inj_en) m_ic = 0;
        else if (acc) m_ic = hit ? 0 : m_ic + 1;
        if (rst) m_valid = 1'b0;
        else if (acc) m_valid = 1'b1;
        else if (xf) m_valid = 1'b0;
        if (rst) begin
            exp_q.delete();
            m_wcnt = 0;
            m_icnt = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        inj_en = 1'b0;
        inj_pos_a = 4'd0;
        inj_pos_b = 4'd0;
        inj_every = 8'd1;
    endtask

    initial begin
        logic [12:1] held;
        int          ic_before;
        tab[0] = '{7'h01, 1'b0, 4'd0,  4'd0,  12'h807, 1'b0};
        tab[1] = '{7'h7F, 1'b0, 4'd0,  4'd0,  12'hFFF, 1'b0};
        tab[2] = '{7'h00, 1'b0, 4'd0,  4'd0,  12'h000, 1'b0};
        tab[3] = '{7'h01, 1'b1, 4'd3,  4'd0,  12'h803, 1'b1};
        tab[4] = '{7'h00, 1'b1, 4'd1,  4'd12, 12'h801, 1'b1};
        tab[5] = '{7'h00, 1'b1, 4'd5,  4'd5,  12'h010, 1'b1};
        tab[6] = '{7'h01, 1'b1, 4'd0,  4'd13, 12'h807, 1'b0};
        tab[7] = '{7'h7F, 1'b1, 4'd15, 4'd12, 12'h7FF, 1'b1};

        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data = 7'h55;
        for (int i = 0; i < 3; i++) step(0, '0, 1'b0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        step(0, '0, 1'b0);

        // Fixed vectors, one isolated word each.
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = tab[i].d;
            inj_en = tab[i].en;
            inj_pos_a = tab[i].pa;
            inj_pos_b = tab[i].pb;
            inj_every = 8'd1;
            step(1, tab[i].code, tab[i].inj);
            bus.in_valid = 1'b0;
            step(0, '0, 1'b0);
            $display("vec %0d data=0x%0h code=0x%0h inj=%0d", i, tab[i].d, bus.out_code, bus.out_injected);
        end
        chk("word_cnt_after_table", int'(word_cnt), 8);

        // Exhaustive clean stream, back-to-back, word_cnt saturates.
        idle_inputs();
        for (int v = 0; v < 128; v++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 7'(v);
            step(0, '0, 1'b0);
        end
        bus.in_valid = 1'b0;
        step(0, '0, 1'b0);
        chk("word_cnt_saturated", int'(word_cnt), CNT_MAX);
        $display("roundtrip 128 words word_cnt=%0d", word_cnt);

        // Period-4 injection on a continuous stream after a fresh reset.
        rst = 1'b1;
        step(0, '0, 1'b0);
        rst = 1'b0;
        inj_en = 1'b1;
        inj_every = 8'd4;
        inj_pos_a = 4'd6;
        ic_before = int'(inj_cnt);
        for (int w = 1; w <= 12; w++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 7'($urandom_range(0, 127));
            step(0, '0, 1'b0);
            chk($sformatf("inj_flag_word%0d", w), int'(bus.out_injected), (w % 4 == 0) ? 1 : 0);
            $display("every4 word %0d code=0x%0h inj=%0d", w, bus.out_code, bus.out_injected);
        end
        bus.in_valid = 1'b0;
        step(0, '0, 1'b0);
        chk("inj_cnt_every4", int'(inj_cnt) - ic_before, 3);
        chk("word_cnt_every4", int'(word_cnt), 12);

        // Random traffic with backpressure and changing injection settings.
        for (int i = 0; i < 300; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data = 7'($urandom_range(0, 127));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            inj_en = 1'($urandom_range(0, 1));
            inj_every = 8'($urandom_range(0, 3));
            inj_pos_a = 4'($urandom_range(0, 15));
            inj_pos_b = 4'($urandom_range(0, 15));
            step(0, '0, 1'b0);
        end
        idle_inputs();
        step(0, '0, 1'b0);
        step(0, '0, 1'b0);
        $display("random traffic done word_cnt=%0d inj_cnt=%0d", word_cnt, inj_cnt);

        // Stall with a held word, then reset must discard it.
        bus.in_valid = 1'b1;
        bus.in_data = 7'h2A;
        step(0, '0, 1'b0);
        held = bus.out_code;
        bus.out_ready = 1'b0;
        bus.in_data = 7'h13;
        for (int i = 0; i < 5; i++) begin
            step(0, '0, 1'b0);
            chk("stall_code_stable", int'(bus.out_code), int'(held));
            chk("stall_in_ready", int'(bus.in_ready), 0);
        end
        rst = 1'b1;
        step(0, '0, 1'b0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("post_rst_valid", int'(bus.out_valid), 0);
        chk("post_rst_word_cnt", int'(word_cnt), 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1'b0);
        chk("held_never_emitted", int'(word_cnt), 0);
        $display("stall/reset held=0x%0h out_valid=%0d word_cnt=%0d", held, bus.out_valid, word_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
